// File: rtl/alu_iter_if.sv
// Execute-stage ALU bus: operand/launch signals toward the ALU, result/flags back.
interface alu_iter_if #(
  parameter int WIDTH = 32
);
  logic             start_in;
  logic [3:0]       opcode_in;
  logic [WIDTH-1:0] s_in;
  logic [WIDTH-1:0] t_in;
  logic [WIDTH-1:0] acc_in;
  logic             carry_in;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] result_out;
  logic             carry_flag_out;
  logic             negative_flag_out;
  logic             overflow_flag_out;
  logic             zero_flag_out;

  // Pipeline side: launches operations and consumes results
  modport master (
    output start_in, opcode_in, s_in, t_in, acc_in, carry_in,
    input  busy_out, done_out, result_out,
           carry_flag_out, negative_flag_out, overflow_flag_out, zero_flag_out
  );

  // ALU side
  modport slave (
    input  start_in, opcode_in, s_in, t_in, acc_in, carry_in,
    output busy_out, done_out, result_out,
           carry_flag_out, negative_flag_out, overflow_flag_out, zero_flag_out
  );
endinterface

// File: rtl/alu_iter.sv
// Registered ALU with ARM-style flags and an iterative shift-add MUL/MLA.
module alu_iter #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic       clk_in,
  input  logic       reset_n_in,
  alu_iter_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;

  state_t           state_q, state_d;
  logic             accept, is_mul_op, mul_last;

  logic [WIDTH-1:0] res_q;
  logic             c_q, n_q, v_q, z_q;
  logic [WIDTH-1:0] mcand_q, mplier_q, prod_q, prod_step;
  logic [CW-1:0]    cnt_q;
  logic             mul_c_q;

  logic [WIDTH-1:0] add_a, add_b, clz_val;
  logic             add_c;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c, sc_v;

  // Launch decode: a start is taken in IDLE and in DONE, never mid-multiply
  always_comb begin
    accept    = bus.start_in && (state_q != ST_MUL);
    is_mul_op = MUL_EN && ((bus.opcode_in == 4'hD) || (bus.opcode_in == 4'hE));
    mul_last  = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH - 1));
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Single-cycle datapath: adder operand selection, CLZ, result and flag choice
  always_comb begin
    add_a = bus.s_in;
    add_b = bus.t_in;
    add_c = 1'b0;
    unique case (bus.opcode_in)
      4'h1:    add_c = bus.carry_in;
      4'h2:    begin add_b = ~bus.t_in; add_c = 1'b1; end
      4'h3:    begin add_b = ~bus.t_in; add_c = bus.carry_in; end
      4'h4:    begin add_a = bus.t_in; add_b = ~bus.s_in; add_c = 1'b1; end
      4'h5:    begin add_a = bus.t_in; add_b = ~bus.s_in; add_c = bus.carry_in; end
      default: ;
    endcase
    sum = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c};

    // Highest set bit wins since the scan runs upward
    clz_val = WIDTH'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (bus.t_in[i]) clz_val = WIDTH'(WIDTH - 1 - i);
    end

    sc_res = '0;
    sc_c   = bus.carry_in;
    sc_v   = v_q;
    unique case (bus.opcode_in)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (add_a[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != add_a[WIDTH-1]);
      end
      4'h6: sc_res = bus.s_in & bus.t_in;
      4'h7: sc_res = bus.s_in & ~bus.t_in;
      4'h8: sc_res = bus.s_in | bus.t_in;
      4'h9: sc_res = bus.s_in ^ bus.t_in;
      4'hA: sc_res = bus.t_in;
      4'hB: sc_res = ~bus.t_in;
      4'hC: sc_res = clz_val;
      // Reserved (and MUL/MLA when not built): zero result, C and V hold
      default: begin
        sc_res = '0;
        sc_c   = c_q;
        sc_v   = v_q;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) state_d = is_mul_op ? ST_MUL : ST_DONE;
        else        state_d = ST_IDLE;
      end
      ST_MUL:  if (mul_last) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs and registered result/flags
  always_comb begin
    bus.busy_out          = (state_q == ST_MUL);
    bus.done_out          = (state_q == ST_DONE);
    bus.result_out        = res_q;
    bus.carry_flag_out    = c_q;
    bus.negative_flag_out = n_q;
    bus.overflow_flag_out = v_q;
    bus.zero_flag_out     = z_q;
  end

  // Result/flag registers and shift-add multiplier state
  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      res_q    <= '0;
      c_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      z_q      <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mul_c_q  <= 1'b0;
    end else if (accept) begin
      if (is_mul_op) begin
        mcand_q  <= bus.s_in;
        mplier_q <= bus.t_in;
        prod_q   <= (bus.opcode_in == 4'hE) ? bus.acc_in : '0;
        cnt_q    <= '0;
        mul_c_q  <= bus.carry_in;
      end else begin
        res_q <= sc_res;
        c_q   <= sc_c;
        v_q   <= sc_v;
        n_q   <= sc_res[WIDTH-1];
        z_q   <= (sc_res == '0);
      end
    end else if (state_q == ST_MUL) begin
      prod_q   <= prod_step;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
      if (mul_last) begin
        res_q <= prod_step;
        c_q   <= mul_c_q;
        n_q   <= prod_step[WIDTH-1];
        z_q   <= (prod_step == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: directed vectors queued on issue, checked on done.
module tb_alu_iter;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        c, n, v, z;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        q_a[$];
  exp_t        q_b[$];
  exp_t        e_a, e_b;
  int          busy_cnt;

  alu_iter_if #(.WIDTH(32)) bus_a ();
  alu_iter_if #(.WIDTH(32)) bus_b ();

  alu_iter #(.WIDTH(32), .MUL_EN(1'b1)) u_dut_a (.clk_in(clk), .reset_n_in(rst_n), .bus(bus_a));
  alu_iter #(.WIDTH(32), .MUL_EN(1'b0)) u_dut_b (.clk_in(clk), .reset_n_in(rst_n), .bus(bus_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic issue_a(input string nm, input logic [3:0] op, input logic [31:0] s, t, acc,
                         input logic c, input logic [31:0] r, input logic ec, en, ev, ez);
    exp_t e;
    bus_a.start_in  = 1'b1;
    bus_a.opcode_in = op;
    bus_a.s_in      = s;
    bus_a.t_in      = t;
    bus_a.acc_in    = acc;
    bus_a.carry_in  = c;
    e.name = nm; e.res = r; e.c = ec; e.n = en; e.v = ev; e.z = ez;
    e.cyc  = cyc + 1 + (((op == 4'hD) || (op == 4'hE)) ? 32 : 0);
    q_a.push_back(e);
    @(negedge clk);
    bus_a.start_in = 1'b0;
  endtask

  // Monitor for the MUL-enabled instance
  always @(negedge clk) begin
    if (bus_a.done_out) begin
      if (q_a.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done_a: got done with result %h at cycle %0d, expected no done",
                 bus_a.result_out, cyc);
      end else begin
        e_a = q_a.pop_front();
        check({e_a.name, "_value"},
              {4'h0, bus_a.result_out, bus_a.carry_flag_out, bus_a.negative_flag_out,
               bus_a.overflow_flag_out, bus_a.zero_flag_out},
              {4'h0, e_a.res, e_a.c, e_a.n, e_a.v, e_a.z});
        check({e_a.name, "_cycle"}, 40'(cyc), 40'(e_a.cyc));
      end
    end
  end

  // Monitor for the MUL-disabled instance
  always @(negedge clk) begin
    if (bus_b.done_out) begin
      if (q_b.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done_b: got done with result %h at cycle %0d, expected no done",
                 bus_b.result_out, cyc);
      end else begin
        e_b = q_b.pop_front();
        check({e_b.name, "_value"},
              {4'h0, bus_b.result_out, bus_b.carry_flag_out, bus_b.negative_flag_out,
               bus_b.overflow_flag_out, bus_b.zero_flag_out},
              {4'h0, e_b.res, e_b.c, e_b.n, e_b.v, e_b.z});
        check({e_b.name, "_cycle"}, 40'(cyc), 40'(e_b.cyc));
      end
    end
  end

  initial begin
    bus_a.start_in = 1'b0; bus_a.opcode_in = 4'h0; bus_a.s_in = '0; bus_a.t_in = '0;
    bus_a.acc_in = '0; bus_a.carry_in = 1'b0;
    bus_b.start_in = 1'b0; bus_b.opcode_in = 4'h0; bus_b.s_in = '0; bus_b.t_in = '0;
    bus_b.acc_in = '0; bus_b.carry_in = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_a", {2'b0, bus_a.busy_out, bus_a.done_out, bus_a.result_out, bus_a.carry_flag_out,
                      bus_a.negative_flag_out, bus_a.overflow_flag_out, bus_a.zero_flag_out}, '0);
    check("reset_b", {2'b0, bus_b.busy_out, bus_b.done_out, bus_b.result_out, bus_b.carry_flag_out,
                      bus_b.negative_flag_out, bus_b.overflow_flag_out, bus_b.zero_flag_out}, '0);
    rst_n = 1'b1;

    // MLA on the instance built without a multiplier is a reserved opcode
    bus_b.start_in = 1'b1; bus_b.opcode_in = 4'hE; bus_b.s_in = 32'd3; bus_b.t_in = 32'd5;
    bus_b.acc_in = 32'hFFFF_FFF2; bus_b.carry_in = 1'b1;
    e_b.name = "mla_disabled"; e_b.res = '0; e_b.c = 1'b0; e_b.n = 1'b0; e_b.v = 1'b0; e_b.z = 1'b1;
    e_b.cyc = cyc + 1;
    q_b.push_back(e_b);

    //       name     op     s             t             acc  cin  result        C     N     V     Z
    issue_a("add",   4'h0, 32'hFFFF_FFFF, 32'h0000_0001, '0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    bus_b.start_in = 1'b0;
    issue_a("sub",   4'h2, 32'h8000_0000, 32'h0000_0001, '0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    issue_a("rsc",   4'h5, 32'h0000_0001, 32'h0000_0000, '0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_a("sub2",  4'h2, 32'h8000_0000, 32'h0000_0001, '0, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
    issue_a("clz16", 4'hC, 32'h0,         32'h0001_0000, '0, 1'b1, 32'd15,        1'b1, 1'b0, 1'b1, 1'b0);
    issue_a("clz0",  4'hC, 32'h0,         32'h0000_0000, '0, 1'b0, 32'd32,        1'b0, 1'b0, 1'b1, 1'b0);

    // Multiply with a stray start at N+5 that must be ignored
    issue_a("mul",   4'hD, 32'h0000_FFFF, 32'h0001_0001, '0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus_a.busy_out) busy_cnt++;
      if (i == 4) begin
        bus_a.start_in = 1'b1; bus_a.opcode_in = 4'h0;
        bus_a.s_in = 32'd7; bus_a.t_in = 32'd9;
      end else if (i == 5) begin
        bus_a.start_in = 1'b0;
      end
      @(negedge clk);
    end
    check("mul_busy_cycles", 40'(busy_cnt), 40'd32);

    issue_a("mla",   4'hE, 32'd3, 32'd5, 32'hFFFF_FFF2, 1'b1, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (40) @(negedge clk);
    check("mla_hold", {4'h0, bus_a.result_out, bus_a.carry_flag_out, bus_a.negative_flag_out,
                       bus_a.overflow_flag_out, bus_a.zero_flag_out}, {4'h0, 32'h1, 4'b1010});

    // Back-to-back single-cycle ops, each launched in the previous op's done cycle
    issue_a("adc",   4'h1, 32'h7FFF_FFFF, 32'h0,         '0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    issue_a("sbc",   4'h3, 32'd5,         32'd5,         '0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0);
    issue_a("rsb",   4'h4, 32'd3,         32'h10,        '0, 1'b0, 32'h0000_000D, 1'b1, 1'b0, 1'b0, 1'b0);
    issue_a("and",   4'h6, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, 1'b1, 32'hF000_F000, 1'b1, 1'b1, 1'b0, 1'b0);
    issue_a("bic",   4'h7, 32'hF0F0_F0F0, 32'hFF00_FF00, '0, 1'b0, 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue_a("orr",   4'h8, 32'h0F0F_0000, 32'h0000_00F0, '0, 1'b1, 32'h0F0F_00F0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue_a("eor",   4'h9, 32'hAAAA_5555, 32'hAAAA_5555, '0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue_a("mov",   4'hA, 32'h0,         32'h8000_0000, '0, 1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0);
    issue_a("mvn",   4'hB, 32'h0,         32'hFFFF_FFFF, '0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    issue_a("rsvd",  4'hF, 32'h1234_5678, 32'h9ABC_DEF0, '0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge clk);

    // Reset in cycle N+10 of a multiply aborts it
    bus_a.start_in = 1'b1; bus_a.opcode_in = 4'hD;
    bus_a.s_in = 32'h0000_FFFF; bus_a.t_in = 32'h0001_0001; bus_a.carry_in = 1'b1;
    @(negedge clk);
    bus_a.start_in = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_mid_mul", {2'b0, bus_a.busy_out, bus_a.done_out, bus_a.result_out, bus_a.carry_flag_out,
                            bus_a.negative_flag_out, bus_a.overflow_flag_out, bus_a.zero_flag_out}, '0);
    rst_n = 1'b1;
    issue_a("add_after_reset", 4'h0, 32'd2, 32'd3, '0, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check("queues_drained", 40'(q_a.size() + q_b.size()), 40'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
